// File: rtl/ddr_dump_ctrl_pkg.sv
// Shared definitions for the DDR dump sequencer: FSM encoding, ddr_control bit map and
// the default half-buffer block size.
package ddr_dump_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReload,
    StRun,
    StDrain
  } dump_state_e;

  localparam int unsigned EN_A  = 0;
  localparam int unsigned EN_B  = 1;
  localparam int unsigned RLD_A = 2;
  localparam int unsigned RLD_B = 3;

  localparam int unsigned BLK_BYTES_DEF = 2048;

endpackage

// File: rtl/ddr_ring_monitor.sv
// Per-channel ring watcher: detects block issues from write-address changes, keeps a
// saturating block count and a sticky overrun flag against the software read pointer.
module ddr_ring_monitor
  import ddr_dump_ctrl_pkg::*;
#(
  parameter int unsigned BLK_BYTES = BLK_BYTES_DEF
) (
  input  logic        buf_clk_i,
  input  logic        buf_rst_i,
  input  logic        clear_i,
  input  logic        track_i,
  input  logic [31:0] base_i,
  input  logic [31:0] end_i,
  input  logic [31:0] curr_i,
  input  logic [31:0] rd_i,
  output logic        issue_o,
  output logic        ovr_evt_o,
  output logic [15:0] blk_o,
  output logic        ovr_o
);

  localparam logic [31:0] BlkBytes = 32'(BLK_BYTES);

  logic [31:0] prev_q;
  logic        prev_vld_q;
  logic [15:0] blk_q;
  logic        ovr_q;
  logic [31:0] size;
  logic [31:0] level;

  assign size    = end_i - base_i;
  // Modular distance from the read pointer, so a wrap back to base never looks full.
  assign level   = (prev_q >= rd_i) ? (prev_q - rd_i) : (size - (rd_i - prev_q));
  assign issue_o   = track_i && prev_vld_q && (curr_i != prev_q);
  assign ovr_evt_o = issue_o && (level >= (size - BlkBytes));

  always_ff @(posedge buf_clk_i) begin
    if (buf_rst_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      blk_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      prev_q     <= curr_i;
      prev_vld_q <= 1'b1;
      if (clear_i) begin
        blk_q <= '0;
        ovr_q <= 1'b0;
      end else begin
        if (issue_o && (blk_q != 16'hFFFF)) blk_q <= blk_q + 16'd1;
        if (ovr_evt_o) ovr_q <= 1'b1;
      end
    end
  end

  assign blk_o = blk_q;
  assign ovr_o = ovr_q;

endmodule

// File: rtl/ddr_dump_ctrl.sv
// Dump session sequencer: drives the master's enable/reload vector, counts issued blocks
// per channel, stops on block quota, stop request or overrun, then drains before done.
module ddr_dump_ctrl
  import ddr_dump_ctrl_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned BLK_BYTES = BLK_BYTES_DEF,
  parameter int unsigned DRAIN_CYC = 64
) (
  input  logic           buf_clk_i,
  input  logic           buf_rst_i,
  input  logic           cfg_start_i,
  input  logic           cfg_stop_i,
  input  logic [NCH-1:0] cfg_en_i,
  input  logic [15:0]    cfg_nblk_i,
  input  logic           cfg_stop_ovr_i,
  input  logic [31:0]    ddr_a_base_i,
  input  logic [31:0]    ddr_a_end_i,
  input  logic [31:0]    ddr_b_base_i,
  input  logic [31:0]    ddr_b_end_i,
  input  logic [31:0]    ddr_a_curr_i,
  input  logic [31:0]    ddr_b_curr_i,
  input  logic [31:0]    sw_a_rd_i,
  input  logic [31:0]    sw_b_rd_i,
  output logic [3:0]     ddr_control_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           irq_o,
  output logic [NCH-1:0] ovr_o,
  output logic [15:0]    blk_a_o,
  output logic [15:0]    blk_b_o
);

  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  dump_state_e    state_q, state_d;
  logic [NCH-1:0] en_act_q, en_act_d;
  logic [15:0]    nblk_q, nblk_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           after_rld_q;
  logic [3:0]     ctrl_q, ctrl_d;
  logic           busy_q, done_q, done_d, irq_q, irq_d;

  logic           start_ok, track;
  logic [NCH-1:0] issue, ovr_evt, nblk_hit;

  assign start_ok = (state_q == StIdle) && cfg_start_i && !cfg_stop_i && (|cfg_en_i);
  // Address moves caused by the pointer reload itself are not block issues.
  assign track    = ((state_q == StRun) || (state_q == StDrain)) && !after_rld_q;

  ddr_ring_monitor #(
    .BLK_BYTES(BLK_BYTES)
  ) u_mon_a (
    .buf_clk_i(buf_clk_i),
    .buf_rst_i(buf_rst_i),
    .clear_i  (start_ok),
    .track_i  (track),
    .base_i   (ddr_a_base_i),
    .end_i    (ddr_a_end_i),
    .curr_i   (ddr_a_curr_i),
    .rd_i     (sw_a_rd_i),
    .issue_o  (issue[0]),
    .ovr_evt_o(ovr_evt[0]),
    .blk_o    (blk_a_o),
    .ovr_o    (ovr_o[0])
  );

  ddr_ring_monitor #(
    .BLK_BYTES(BLK_BYTES)
  ) u_mon_b (
    .buf_clk_i(buf_clk_i),
    .buf_rst_i(buf_rst_i),
    .clear_i  (start_ok),
    .track_i  (track),
    .base_i   (ddr_b_base_i),
    .end_i    (ddr_b_end_i),
    .curr_i   (ddr_b_curr_i),
    .rd_i     (sw_b_rd_i),
    .issue_o  (issue[1]),
    .ovr_evt_o(ovr_evt[1]),
    .blk_o    (blk_b_o),
    .ovr_o    (ovr_o[1])
  );

  assign nblk_hit[0] = (nblk_q != 16'd0) && (blk_a_o >= nblk_q);
  assign nblk_hit[1] = (nblk_q != 16'd0) && (blk_b_o >= nblk_q);

  always_comb begin
    state_d  = state_q;
    en_act_d = en_act_q;
    nblk_d   = nblk_q;
    drain_d  = drain_q;
    done_d   = done_q;
    irq_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d  = StReload;
          en_act_d = cfg_en_i;
          nblk_d   = cfg_nblk_i;
          done_d   = 1'b0;
        end
      end
      StReload: begin
        drain_d = '0;
        state_d = cfg_stop_i ? StDrain : StRun;
      end
      StRun: begin
        drain_d  = '0;
        en_act_d = en_act_q & ~nblk_hit;
        if (cfg_stop_i || (en_act_d == '0) || (cfg_stop_ovr_i && (|ovr_evt))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (|issue) begin
          drain_d = '0;
        end else if (drain_q == DW'(DRAIN_CYC - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          irq_d   = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control vector is registered from the next state so it lines up with the state.
  always_comb begin
    ctrl_d = '0;
    if (state_d == StReload) begin
      ctrl_d[RLD_A] = en_act_d[0];
      ctrl_d[RLD_B] = en_act_d[1];
    end else if (state_d == StRun) begin
      ctrl_d[EN_A] = en_act_d[0];
      ctrl_d[EN_B] = en_act_d[1];
    end
  end

  always_ff @(posedge buf_clk_i) begin
    if (buf_rst_i) begin
      state_q     <= StIdle;
      en_act_q    <= '0;
      nblk_q      <= '0;
      drain_q     <= '0;
      after_rld_q <= 1'b0;
      ctrl_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_act_q    <= en_act_d;
      nblk_q      <= nblk_d;
      drain_q     <= drain_d;
      after_rld_q <= (state_q == StReload);
      ctrl_q      <= ctrl_d;
      busy_q      <= (state_d != StIdle);
      done_q      <= done_d;
      irq_q       <= irq_d;
    end
  end

  assign ddr_control_o = ctrl_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign irq_o         = irq_q;

endmodule
